// File: rtl/opc5ls_pkg.sv
// Shared definitions for the opc5ls bus responder: FSM encodings, IO page
// register offsets and CTRL/STATUS bit positions.
package opc5ls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [1:0] OFS_RELOAD = 2'd0;
  localparam logic [1:0] OFS_COUNT  = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int CTRL_TIMER_EN  = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STATUS_PENDING = 0;

endpackage

// File: rtl/opc5ls_sram.sv
// Single-port synchronous RAM with a registered read port.
// The read register only changes on a read enable, so it holds between reads.
module opc5ls_sram
  import opc5ls_pkg::*;
#(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [15:0]          wdata_i,
  output logic [15:0]          rdata_o
);

  logic [15:0] mem_q [2**ADDR_BITS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/opc5ls_bus_responder.sv
// Memory-side target for the opc5ls CPU bus: stalls the CPU via clken for a
// programmable number of wait states, serves RAM or the timer IO page.
module opc5ls_bus_responder
  import opc5ls_pkg::*;
#(
  parameter int          ADDR_BITS   = 11,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mreq_b_i,
  input  logic        rnw_i,
  input  logic [15:0] address_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        clken_o,
  output logic        int_b_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        accept;
  logic        ramHit, ioHit;
  logic [15:0] ioOffset;
  logic [1:0]  ioSel;
  logic        ramRe, ramWe;
  logic [15:0] ramRdata;
  logic [15:0] ioReadVal;
  logic        rdSrcRam_q;
  logic [15:0] ioRdata_q;

  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        intB_q, intB_d;
  logic        ioWrite, reloadWr, ctrlWr, statusWr;
  logic        enableRise, expire;

  // Requests presented while reset is held must not commit anything.
  assign accept   = (state_q == ST_IDLE) && !mreq_b_i && !reset_i;
  assign ramHit   = address_i < IO_BASE;
  assign ioOffset = address_i - IO_BASE;
  assign ioHit    = !ramHit && (ioOffset < 16'd4);
  assign ioSel    = ioOffset[1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT_INIT == 4'd0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (waitCnt_q == 4'd1) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clken_o = 1'b0;
    if (reset_i || state_q == ST_ACK || (state_q == ST_IDLE && mreq_b_i)) clken_o = 1'b1;
  end

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (accept)                  waitCnt_d = WAIT_INIT;
    else if (state_q == ST_WAIT) waitCnt_d = waitCnt_q - 4'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) waitCnt_q <= '0;
    else         waitCnt_q <= waitCnt_d;
  end

  assign ramRe = accept && rnw_i && ramHit;
  assign ramWe = accept && !rnw_i && ramHit;

  opc5ls_sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .we_i    (ramWe),
    .re_i    (ramRe),
    .addr_i  (address_i[ADDR_BITS-1:0]),
    .wdata_i (wdata_i),
    .rdata_o (ramRdata)
  );

  always_comb begin
    ioReadVal = '0;
    if (ioHit) begin
      case (ioSel)
        OFS_RELOAD: ioReadVal = reload_q;
        OFS_COUNT:  ioReadVal = count_q;
        OFS_CTRL:   ioReadVal = {14'd0, ctrl_q};
        OFS_STATUS: ioReadVal = {15'd0, pending_q};
        default:    ioReadVal = '0;
      endcase
    end
  end

  // rdata is either the RAM read register or the IO capture, chosen per read.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdSrcRam_q <= 1'b0;
      ioRdata_q  <= '0;
    end else if (accept && rnw_i) begin
      rdSrcRam_q <= ramHit;
      ioRdata_q  <= ioReadVal;
    end
  end

  assign rdata_o = rdSrcRam_q ? ramRdata : ioRdata_q;

  assign ioWrite    = accept && !rnw_i && ioHit;
  assign reloadWr   = ioWrite && (ioSel == OFS_RELOAD);
  assign ctrlWr     = ioWrite && (ioSel == OFS_CTRL);
  assign statusWr   = ioWrite && (ioSel == OFS_STATUS);
  assign enableRise = ctrlWr && wdata_i[CTRL_TIMER_EN] && !ctrl_q[CTRL_TIMER_EN];
  assign expire     = ctrl_q[CTRL_TIMER_EN] && (count_q == 16'd0);

  // Expiry beats a same-cycle W1C; int_b tracks the next-state values.
  always_comb begin
    reload_d  = reloadWr ? wdata_i : reload_q;
    ctrl_d    = ctrlWr ? wdata_i[1:0] : ctrl_q;
    count_d   = count_q;
    if (enableRise)                 count_d = reload_q;
    else if (ctrl_q[CTRL_TIMER_EN]) count_d = expire ? reload_q : count_q - 16'd1;
    pending_d = pending_q;
    if (statusWr && wdata_i[STATUS_PENDING]) pending_d = 1'b0;
    if (expire)                              pending_d = 1'b1;
    intB_d    = !(pending_d && ctrl_d[CTRL_IRQ_EN]);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reload_q  <= '0;
      count_q   <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      intB_q    <= 1'b1;
    end else begin
      reload_q  <= reload_d;
      count_q   <= count_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      intB_q    <= intB_d;
    end
  end

  assign int_b_o = intB_q;

endmodule

// File: doc/opc5ls_bus_responder.md
Name: opc5ls_bus_responder

Overview:
- Memory-side target for the opc5ls CPU bus. Decodes each bus request and serves it from on-chip RAM or a small IO register page.
- Stretches accesses with programmable wait states by driving the CPU's clock-enable.
- Provides a reload timer that raises the CPU's active-low interrupt request.
- Sits directly between the CPU core and system memory; it is the responder for every CPU read, fetch and store.

Parameters:
- ADDR_BITS, 11: RAM address width; RAM holds 2**ADDR_BITS 16-bit words.
- WAIT_STATES, 0: extra stall cycles per access (0..15).
- IO_BASE, 16'hFE00: first address of the IO page; the page is IO_BASE..IO_BASE+3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mreq_b  in  1  active-low memory request from CPU
- rnw  in  1  1 = read, 0 = write
- address  in  16  word address
- wdata  in  16  CPU write data (CPU dout)
- rdata  out  16  read data to CPU (CPU din)
- clken  out  1  CPU clock enable; low stalls the CPU
- int_b  out  1  active-low interrupt request

Behaviour:
- Bus rule: a transfer completes on the rising edge where mreq_b=0 and clken=1. The CPU holds address, rnw and wdata stable while clken=0.
- FSM states: IDLE, WAIT, ACK. Reset (async) forces IDLE, rdata=0, wait counter=0, all IO registers=0, int_b=1.
- clken=1 while reset is asserted, because the CPU only samples its reset when clken=1.
- clken is combinational: 1 in ACK; 1 in IDLE when mreq_b=1; 0 otherwise.
- IDLE with mreq_b=0 (accept):
  - For a read, issue the RAM/IO read.
  - For a write, commit wdata to RAM/IO on this edge.
  - Load counter=WAIT_STATES.
  - Next state is ACK if WAIT_STATES=0, else WAIT.
- IDLE with mreq_b=1: remain in IDLE.
- WAIT: decrement counter; go to ACK when counter=1.
- ACK: rdata holds the registered read result; next state is IDLE.
- Access length:
  - Each access stalls WAIT_STATES+1 cycles and occupies WAIT_STATES+2 cycles total.
  - Back-to-back requests are re-accepted in IDLE with no extra gap.
- rdata: registered, updated only by a read accept; it holds its value otherwise.
- Decode:
  - address < IO_BASE maps to RAM[address[ADDR_BITS-1:0]]; the RAM is aliased across that range.
  - IO_BASE..IO_BASE+3 maps to registers.
  - IO_BASE+4..16'hFFFF: reads return 0, writes are ignored.
- IO registers, by offset from IO_BASE:
  - +0 RELOAD (rw, 16 bits)
  - +1 COUNT (ro); writes are ignored
  - +2 CTRL (rw, bits[1:0]; bit0 = timer enable, bit1 = irq enable; upper bits read 0)
  - +3 STATUS (bit0 = pending; write 1 to bit0 clears it; other bits read 0)
- Timer: runs on every clk, not gated by clken.
  - CTRL.bit0 0->1 write loads COUNT=RELOAD.
  - While enabled: if COUNT=0, set pending and reload COUNT=RELOAD; else decrement COUNT.
  - Period is RELOAD+1 cycles.
  - A RELOAD write during counting takes effect at the next expiry.
  - Disabling freezes COUNT.
- int_b = !(pending & CTRL.bit1), registered.
- Simultaneous events:
  - Timer expiry in the same cycle as a STATUS W1C: pending stays 1 (set wins).
  - A CTRL enable write in the same cycle as expiry: the load from the write wins.
- Reset mid-access: the FSM aborts to IDLE. Any write already committed in IDLE stays committed; nothing else is written. clken=1 after reset when mreq_b=1.

Decomposition:
- Shared package opc5ls_pkg holds:
  - FSM state encodings.
  - IO register offsets (OFS_RELOAD=0, OFS_COUNT=1, OFS_CTRL=2, OFS_STATUS=3).
  - CTRL/STATUS bit indices.
- Sub-module opc5ls_sram: single-port synchronous RAM, 2**ADDR_BITS x 16, registered read, write-enable. The bus responder holds the FSM, decode, timer and interrupt logic.

Test Plan:
- WAIT_STATES=0: write 16'h1234 to 16'h0010, then read 16'h0010 → clken low exactly 1 cycle per access, rdata=16'h1234 in the ACK cycle.
- WAIT_STATES=3: read RAM → clken low 4 consecutive cycles, then high 1 cycle with correct rdata; back-to-back reads show no idle gap.
- RELOAD=5, CTRL=3 → pending sets and int_b goes low 6 cycles after the enable edge, then every 6 cycles; COUNT reads back within 0..5.
- Write STATUS=1 on the exact expiry cycle → int_b stays low. A W1C one cycle later → int_b high next cycle.
- Assert reset during WAIT → clken=1, rdata=0, int_b=1 immediately. After release, a fresh read completes correctly and the aborted read leaves no side effects.
- Read IO_BASE+7 → 0. Read 16'h0810 with ADDR_BITS=11 → returns the RAM[16'h0010] alias value. A write to COUNT leaves COUNT unchanged.
